eth_rx_fcs_check: RTL
=====================

Name: eth_rx_fcs_check

Overview:
- Sits directly downstream of the RMII/MII receive MAC in the receive clock domain. Consumes its byte stream: data, valid, error user bit and last.
- Checks CRC-32 (FCS), frame length and MAC error on each frame, and strips the 4 FCS bytes.
- Emits the payload stream with a single end-of-frame error flag and a per-frame status pulse.
- No backpressure anywhere, because the upstream MAC has no ready. The block must accept one byte per cycle indefinitely.

Parameters:
- MIN_FRAME_LEN, 64: minimum legal frame length in bytes, FCS included. Shorter frames are flagged as runts.
- MAX_FRAME_LEN, 1522: maximum legal frame length in bytes, FCS included. Longer frames are flagged as oversize.
- LEN_WIDTH, 11: width of the byte counter and of frame_len. The counter saturates at 2^LEN_WIDTH-1.

Ports:
- clock, input, 1: receive clock.
- aresetn, input, 1: asynchronous active-low reset.
- saxis_tdata, input, 8: received byte from the MAC.
- saxis_tvalid, input, 1: byte valid.
- saxis_tuser, input, 1: MAC error (RX_ER/abort); sticky for the current frame.
- saxis_tlast, input, 1: last byte of frame; this byte is the final FCS byte.
- maxis_tdata, output, 8: payload byte.
- maxis_tvalid, output, 1: payload byte valid.
- maxis_tuser, output, 1: frame bad; meaningful only on the beat with maxis_tlast.
- maxis_tlast, output, 1: last payload byte.
- frame_done, output, 1: one-cycle pulse per input frame end, including dropped frames.
- frame_len, output, LEN_WIDTH: input byte count of the finished frame, FCS included; valid while frame_done is high.
- frame_status, output, 4: {drop, oversize, runt, fcs_bad} for the finished frame; bad MAC error is folded into fcs_bad=1; valid while frame_done is high.

Behaviour:
- Reset: all outputs 0. The delay line, fill count, byte count, error flags and CRC register are cleared; the CRC register is set to 0xFFFFFFFF.

Delay line
- 4-byte shift register with a fill count of 0..4.
- On each input beat with fill==4, the oldest byte is emitted and the new byte is shifted in.
- Outputs are registered, so latency is one cycle from the input beat to the output beat.
- maxis_tlast equals saxis_tlast of that input beat. The last emitted byte is therefore byte N-5 (0-based) of an N-byte frame.
- Gaps in saxis_tvalid are allowed; maxis_tvalid mirrors them one cycle later.

CRC
- Reflected polynomial 0xEDB88320, byte processed LSB first, initial value 0xFFFFFFFF.
- Runs over every input byte, FCS included.
- The frame is good when the register equals the residue 0xDEBB20E3 after the tlast byte.

Length and error flags
- Byte count increments on each beat and saturates.
- runt = N < MIN_FRAME_LEN. oversize = N > MAX_FRAME_LEN.
- MAC error flag: set by saxis_tuser on any beat of the frame, cleared at frame end.
- maxis_tuser on the tlast beat = fcs_bad | runt | oversize | mac_error.

Frame end
- On the saxis_tlast beat: pulse frame_done, drive frame_len and frame_status in the same cycle as maxis_tlast, then reset fill, count, flags and CRC for the next frame.
- A new frame may start on the very next cycle.
- N <= 4: nothing is emitted on maxis. frame_done pulses with drop=1 and runt=1.

State machine: IDLE -> FILL (fill<4) -> PASS (fill==4) -> IDLE on tlast.
- tlast in FILL: drop path.
- tlast in PASS: normal end.

Boundary cases
- Asynchronous reset mid-frame aborts the frame with no tlast and no frame_done emitted. The downstream consumer must also be reset.
- A frame whose count reaches saturation is still flagged oversize. frame_len reads the saturated value.

Optional Feature:
- Macro: ETH_RX_FCS_CHECK_STATS_EN.
- When defined, adds the outputs stat_good, stat_bad and stat_drop, each 32 bits.
  - Each counter increments on frame_done according to frame_status.
  - Counters wrap at 2^32, reset to 0, and are cleared by a 1-cycle input stat_clear. stat_clear wins over a simultaneous increment.
- When undefined, these ports and registers do not exist. Core behaviour is identical either way.

Decomposition:
- Package eth_pkg holds:
  - CRC32_POLY_REFLECTED = 0xEDB88320, CRC32_INIT = 0xFFFFFFFF, CRC32_RESIDUE = 0xDEBB20E3.
  - ETH_MIN_FRAME_LEN = 64, ETH_MAX_FRAME_LEN = 1522.
  - A typedef for frame_status {drop, oversize, runt, fcs_bad}.
- One sub-module, eth_crc32_d8: combinational next-CRC from (crc[31:0], data[7:0]). It is shared with a future TX FCS generator.

Test Plan:
1. 64-byte frame: bytes 0x00..0x3B plus a correct FCS computed by the bench model -> 60 output beats 0x00..0x3B, each one cycle after input; tlast on 0x3B; tuser=0; frame_done with frame_len=64 and status=0000.
2. Same frame with bit 0 of byte 10 flipped -> same 60 beats; tuser=1 on tlast; status=0001.
3. 30-byte frame with valid FCS -> 26 beats; tuser=1; status=0010; then a 3-byte frame -> no output beats, frame_done with status=1010 and frame_len=3.
4. Valid 64-byte frame with saxis_tuser=1 on byte 20 only, tvalid toggling every other cycle -> 60 beats with matching gaps; tuser=1; fcs_bad=1. A back-to-back valid frame on the next cycle must then pass clean.
5. 1530-byte frame with valid FCS -> tuser=1, oversize=1, frame_len=1530. Separately, aresetn asserted after byte 30 -> all outputs 0 immediately; a following valid 64-byte frame passes with status=0000.
6. With ETH_RX_FCS_CHECK_STATS_EN defined: run scenarios 1–3 -> stat_good=1, stat_bad=3, stat_drop=1. stat_clear coinciding with frame_done -> all counters 0.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet constants and types for the receive FCS checker and a future TX FCS generator.
package eth_pkg;

   localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT           = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE        = 32'hDEBB20E3;

   localparam int ETH_MIN_FRAME_LEN = 64;
   localparam int ETH_MAX_FRAME_LEN = 1522;

   typedef struct packed {
      logic drop;
      logic oversize;
      logic runt;
      logic fcs_bad;
   } frame_status_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_PASS = 2'd2
   } rx_state_e;

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational CRC-32 update for one byte, reflected polynomial, byte consumed LSB first.
module eth_crc32_d8
   import eth_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data_in,
   output logic [31:0] crc_out
);

   logic [31:0] c;

   always_comb begin
      c = crc_in ^ {24'd0, data_in};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFLECTED) : (c >> 1);
      end
      crc_out = c;
   end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// Receive FCS/length/MAC-error checker that strips the 4 FCS bytes through a 4-byte delay line.
// Optional per-frame statistics counters are enabled with ETH_RX_FCS_CHECK_STATS_EN.
module eth_rx_fcs_check
   import eth_pkg::*;
#(
   parameter int MIN_FRAME_LEN = ETH_MIN_FRAME_LEN,
   parameter int MAX_FRAME_LEN = ETH_MAX_FRAME_LEN,
   parameter int LEN_WIDTH     = 11
) (
   input  logic                 clock,
   input  logic                 aresetn,
   input  logic [7:0]           saxis_tdata,
   input  logic                 saxis_tvalid,
   input  logic                 saxis_tuser,
   input  logic                 saxis_tlast,
   output logic [7:0]           maxis_tdata,
   output logic                 maxis_tvalid,
   output logic                 maxis_tuser,
   output logic                 maxis_tlast,
   output logic                 frame_done,
   output logic [LEN_WIDTH-1:0] frame_len,
   output logic [3:0]           frame_status
`ifdef ETH_RX_FCS_CHECK_STATS_EN
   ,
   input  logic                 stat_clear,
   output logic [31:0]          stat_good,
   output logic [31:0]          stat_bad,
   output logic [31:0]          stat_drop
`endif
);

   localparam logic [LEN_WIDTH-1:0] MIN_LEN = LEN_WIDTH'(MIN_FRAME_LEN);
   localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_FRAME_LEN);

   rx_state_e            state_q, state_d;
   logic [2:0]           fill_q, fill_d;
   logic [7:0]           dly_q [4];
   logic [7:0]           dly_d [4];
   logic [7:0]           dly_shift [4];
   logic [LEN_WIDTH-1:0] count_q, count_d, count_inc;
   logic                 mac_err_q, mac_err_d, mac_now;
   logic [31:0]          crc_q, crc_d, crc_next;
   frame_status_t        status_now;

   logic [7:0]           m_tdata_q, m_tdata_d;
   logic                 m_tvalid_q, m_tvalid_d;
   logic                 m_tuser_q, m_tuser_d;
   logic                 m_tlast_q, m_tlast_d;
   logic                 done_q, done_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   frame_status_t        status_q, status_d;

   logic beat, frame_end;
   assign beat      = saxis_tvalid;
   assign frame_end = saxis_tvalid & saxis_tlast;

   eth_crc32_d8 u_crc (
      .crc_in  (crc_q),
      .data_in (saxis_tdata),
      .crc_out (crc_next)
   );

   assign dly_shift[0] = saxis_tdata;
   generate
      for (genvar gi = 1; gi < 4; gi++) begin : g_shift
         assign dly_shift[gi] = dly_q[gi-1];
      end
   endgenerate

   assign count_inc = (count_q == {LEN_WIDTH{1'b1}}) ? count_q : count_q + 1'b1;
   assign mac_now   = mac_err_q | saxis_tuser;

   // With fewer than 5 bytes there is no complete FCS behind a payload, so only the MAC error counts as bad.
   always_comb begin
      status_now.drop     = (state_q != ST_PASS);
      status_now.oversize = (count_inc > MAX_LEN);
      status_now.runt     = (count_inc < MIN_LEN);
      status_now.fcs_bad  = mac_now | ((state_q == ST_PASS) & (crc_next != CRC32_RESIDUE));
   end

   always_ff @(posedge clock or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (beat && !saxis_tlast) state_d = ST_FILL;
         ST_FILL: begin
            if (frame_end)                 state_d = ST_IDLE;
            else if (beat && fill_q == 3'd3) state_d = ST_PASS;
         end
         ST_PASS: if (frame_end) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      fill_d     = fill_q;
      dly_d      = dly_q;
      count_d    = count_q;
      mac_err_d  = mac_err_q;
      crc_d      = crc_q;
      m_tdata_d  = 8'd0;
      m_tvalid_d = 1'b0;
      m_tuser_d  = 1'b0;
      m_tlast_d  = 1'b0;
      done_d     = 1'b0;
      len_d      = '0;
      status_d   = '0;
      if (beat) begin
         dly_d     = dly_shift;
         crc_d     = crc_next;
         count_d   = count_inc;
         mac_err_d = mac_now;
         if (fill_q != 3'd4) fill_d = fill_q + 3'd1;
         if (state_q == ST_PASS) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = dly_q[3];
            m_tlast_d  = saxis_tlast;
            m_tuser_d  = saxis_tlast & (|status_now);
         end
         if (saxis_tlast) begin
            done_d    = 1'b1;
            len_d     = count_inc;
            status_d  = status_now;
            fill_d    = 3'd0;
            count_d   = '0;
            mac_err_d = 1'b0;
            crc_d     = CRC32_INIT;
         end
      end
   end

   always_ff @(posedge clock or negedge aresetn) begin
      if (!aresetn) begin
         fill_q     <= 3'd0;
         for (int i = 0; i < 4; i++) dly_q[i] <= 8'd0;
         count_q    <= '0;
         mac_err_q  <= 1'b0;
         crc_q      <= CRC32_INIT;
         m_tdata_q  <= 8'd0;
         m_tvalid_q <= 1'b0;
         m_tuser_q  <= 1'b0;
         m_tlast_q  <= 1'b0;
         done_q     <= 1'b0;
         len_q      <= '0;
         status_q   <= '0;
      end else begin
         fill_q     <= fill_d;
         dly_q      <= dly_d;
         count_q    <= count_d;
         mac_err_q  <= mac_err_d;
         crc_q      <= crc_d;
         m_tdata_q  <= m_tdata_d;
         m_tvalid_q <= m_tvalid_d;
         m_tuser_q  <= m_tuser_d;
         m_tlast_q  <= m_tlast_d;
         done_q     <= done_d;
         len_q      <= len_d;
         status_q   <= status_d;
      end
   end

   assign maxis_tdata  = m_tdata_q;
   assign maxis_tvalid = m_tvalid_q;
   assign maxis_tuser  = m_tuser_q;
   assign maxis_tlast  = m_tlast_q;
   assign frame_done   = done_q;
   assign frame_len    = len_q;
   assign frame_status = status_q;

`ifdef ETH_RX_FCS_CHECK_STATS_EN
   logic [31:0] good_q, good_d, bad_q, bad_d, drop_q, drop_d;

   // Counters follow the registered status, so a clear during the frame_done cycle discards that frame.
   always_comb begin
      good_d = good_q;
      bad_d  = bad_q;
      drop_d = drop_q;
      if (stat_clear) begin
         good_d = 32'd0;
         bad_d  = 32'd0;
         drop_d = 32'd0;
      end else if (done_q) begin
         if (status_q == '0) good_d = good_q + 32'd1;
         else                bad_d  = bad_q + 32'd1;
         if (status_q.drop)  drop_d = drop_q + 32'd1;
      end
   end

   always_ff @(posedge clock or negedge aresetn) begin
      if (!aresetn) begin
         good_q <= 32'd0;
         bad_q  <= 32'd0;
         drop_q <= 32'd0;
      end else begin
         good_q <= good_d;
         bad_q  <= bad_d;
         drop_q <= drop_d;
      end
   end

   assign stat_good = good_q;
   assign stat_bad  = bad_q;
   assign stat_drop = drop_q;
`endif

endmodule
